// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one video BRAM port between display reads (fixed priority)
// and a valid/ready host master with anti-starvation. Optional stats: VRAM_ARB_STATS_EN.
module vram_arbiter #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int MAX_WAIT  = 15,
  parameter int WAIT_BITS = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   disp_en_i,
  input  logic [ADDR_BITS-1:0]   disp_addr_i,
  output logic [DATA_BITS-1:0]   disp_dout_o,
  output logic                   disp_conflict_o,
  input  logic                   host_valid_i,
  output logic                   host_ready_o,
  input  logic [ADDR_BITS-1:0]   host_addr_i,
  input  logic [DATA_BITS/8-1:0] host_we_i,
  input  logic [DATA_BITS-1:0]   host_din_i,
  output logic                   host_rvalid_o,
  output logic [DATA_BITS-1:0]   host_rdata_o,
  output logic                   bram_clk_o,
  output logic                   bram_rst_o,
  output logic                   bram_en_o,
  output logic [ADDR_BITS-1:0]   bram_addr_o,
  output logic [DATA_BITS-1:0]   bram_din_o,
  output logic [DATA_BITS/8-1:0] bram_we_o,
  input  logic [DATA_BITS-1:0]   bram_dout_i
`ifdef VRAM_ARB_STATS_EN
  ,
  input  logic                   stat_clr_i,
  output logic [31:0]            stat_host_grants_o,
  output logic [31:0]            stat_conflicts_o
`endif
);

  typedef enum logic [1:0] {IDLE, DISP, HOST, FORCE} state_e;

  state_e               state, state_nxt;
  logic [WAIT_BITS-1:0] wait_cnt;
  logic                 rd_pend;
  logic                 starve, grant_host, grant_disp;

  assign bram_clk_o  = clk_i;
  assign bram_rst_o  = ~reset_ni;
  assign disp_dout_o = bram_dout_i;

  assign starve = (wait_cnt == WAIT_BITS'(MAX_WAIT));
  // Grants are gated by reset_ni so the BRAM port stays quiet while in reset.
  assign grant_host = reset_ni & host_valid_i & (~disp_en_i | starve);
  assign grant_disp = reset_ni & disp_en_i & ~grant_host;

  assign host_ready_o    = grant_host;
  assign bram_en_o       = grant_host | grant_disp;
  assign disp_conflict_o = (state == FORCE);

  always_comb begin
    bram_addr_o = '0;
    bram_we_o   = '0;
    bram_din_o  = '0;
    if (grant_host) begin
      bram_addr_o = host_addr_i;
      bram_we_o   = host_we_i;
      bram_din_o  = host_din_i;
    end else if (grant_disp) begin
      bram_addr_o = disp_addr_i;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    if (grant_host && disp_en_i) state_nxt = FORCE;
    else if (grant_host)         state_nxt = HOST;
    else if (grant_disp)         state_nxt = DISP;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wait_cnt <= '0;
    end else if (!host_valid_i || grant_host) begin
      wait_cnt <= '0;
    end else if (!starve) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Read pipeline: accept -> capture BRAM data next cycle -> rvalid the cycle after.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_pend       <= 1'b0;
      host_rvalid_o <= 1'b0;
      host_rdata_o  <= '0;
    end else begin
      rd_pend       <= grant_host && (host_we_i == '0);
      host_rvalid_o <= rd_pend;
      if (rd_pend) host_rdata_o <= bram_dout_i;
    end
  end

`ifdef VRAM_ARB_STATS_EN
  // Clear takes precedence over a same-cycle increment.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      stat_host_grants_o <= '0;
      stat_conflicts_o   <= '0;
    end else if (stat_clr_i) begin
      stat_host_grants_o <= '0;
      stat_conflicts_o   <= '0;
    end else begin
      if (grant_host)       stat_host_grants_o <= stat_host_grants_o + 32'd1;
      if (state == FORCE)   stat_conflicts_o   <= stat_conflicts_o + 32'd1;
    end
  end
`endif

endmodule
